// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store unit.
//   - MemOp (func3) encodings
//   - controller state enum
//   - request legality helpers
// Optional feature macro: LSU_MISALIGN_TRAP_EN (adds the misalignment check).
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Stores have no unsigned variants, so BU/HU are only legal for loads.
  function automatic logic memop_legal(input logic wr, input logic [2:0] memop);
    if (wr) return (memop inside {MEMOP_B, MEMOP_H, MEMOP_W});
    else    return (memop inside {MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU});
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // memop[1:0] encodes the access size: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] memop, input logic [1:0] a);
    case (memop[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction
`endif

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment and extension (combinational).
// Ports:
//   i_rdata  [31:0]  raw word from data memory
//   i_addr   [1:0]   low byte-address bits of the access
//   i_memop  [2:0]   MemOp (func3)
//   o_data   [31:0]  lane-selected, sign/zero-extended load result
// Halfword selection uses only addr[1]; word ignores the low bits entirely.
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_memop,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign_en;

  assign w_byte    = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half    = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  // memop[2] set means unsigned (BU/HU)
  assign w_sign_en = ~i_memop[2];

  always_comb begin
    o_data = i_rdata;
    case (i_memop[1:0])
      2'b00:   o_data = {{24{w_sign_en & w_byte[7]}}, w_byte};
      2'b01:   o_data = {{16{w_sign_en & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: takes one core request, issues one word-aligned
// bus transaction with byte strobes, returns extended load data or a store ack.
// Only DATA_W = 32 is supported.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned H/HU/W accesses
// are rejected with o_resp_err instead of being silently aligned.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   i_req_valid/o_req_ready        core request handshake
//   i_req_wr, i_req_memop          MemWr, MemOp (func3)
//   i_req_addr, i_req_wdata        byte address, right-aligned store data
//   o_resp_valid/i_resp_ready      core response handshake
//   o_resp_rdata, o_resp_err       load result (0 for stores/errors), error flag
//   o_mem_req_valid/i_mem_req_ready bus request handshake
//   o_mem_addr, o_mem_wen          word address, write enable
//   o_mem_wstrb, o_mem_wdata       byte strobes, lane-replicated store data
//   i_mem_rsp_valid, i_mem_rdata   one-cycle bus response, read word
//
// state | meaning
// IDLE  | ready for a request
// REQ   | bus request presented, waiting for i_mem_req_ready
// WAIT  | waiting for the bus response
// DONE  | response presented to the core
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [2:0]        i_req_memop,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [3:0]        o_mem_wstrb,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_rsp_valid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  state_t            r_state;
  state_t            w_next;
  logic              r_wr;
  logic [2:0]        r_memop;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              w_illegal;
  logic [DATA_W-1:0] w_load_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_illegal = !memop_legal(i_req_wr, i_req_memop) || misaligned(i_req_memop, i_req_addr[1:0]);
`else
  assign w_illegal = !memop_legal(i_req_wr, i_req_memop);
`endif

  // State register: reset forces IDLE at once, so o_mem_req_valid drops
  // asynchronously and a late bus response lands in IDLE where it is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (i_req_valid)     w_next = w_illegal ? DONE : REQ;
      REQ:  if (i_mem_req_ready) w_next = WAIT;
      WAIT: if (i_mem_rsp_valid) w_next = DONE;
      DONE: if (i_resp_ready)    w_next = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready     = (r_state == IDLE);
    o_mem_req_valid = (r_state == REQ);
    o_resp_valid    = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= 1'b0;
      r_memop <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == IDLE && i_req_valid) begin
      r_wr    <= i_req_wr;
      r_memop <= i_req_memop;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
      r_rdata <= '0;
      r_err   <= w_illegal;
    end else if (r_state == WAIT && i_mem_rsp_valid) begin
      r_rdata <= r_wr ? '0 : w_load_data;
    end
  end

  lsu_load_align u_load_align (
    .i_rdata (i_mem_rdata),
    .i_addr  (r_addr[1:0]),
    .i_memop (r_memop),
    .o_data  (w_load_data)
  );

  assign o_mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_wen    = r_wr;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

  always_comb begin
    o_mem_wstrb = 4'b0000;
    o_mem_wdata = r_wdata;
    if (r_wr) begin
      case (r_memop[1:0])
        2'b00: begin
          o_mem_wstrb = 4'b0001 << r_addr[1:0];
          o_mem_wdata = {4{r_wdata[7:0]}};
        end
        2'b01: begin
          o_mem_wstrb = r_addr[1] ? 4'b1100 : 4'b0011;
          o_mem_wdata = {2{r_wdata[15:0]}};
        end
        default: o_mem_wstrb = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_wr = 1'b0;
  logic [2:0]  i_req_memop = 3'b000;
  logic [31:0] i_req_addr = '0;
  logic [31:0] i_req_wdata = '0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready = 1'b0;
  logic [31:0] o_mem_addr;
  logic        o_mem_wen;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_wr        (i_req_wr),
    .i_req_memop     (i_req_memop),
    .i_req_addr      (i_req_addr),
    .i_req_wdata     (i_req_wdata),
    .o_resp_valid    (o_resp_valid),
    .i_resp_ready    (i_resp_ready),
    .o_resp_rdata    (o_resp_rdata),
    .o_resp_err      (o_resp_err),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wen       (o_mem_wen),
    .o_mem_wstrb     (o_mem_wstrb),
    .o_mem_wdata     (o_mem_wdata),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rdata     (i_mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // transaction observations
  logic        t_bus_seen, t_wen, t_req_stable, t_resp_stable, t_timeout, t_err;
  logic [31:0] t_addr, t_wdata, t_rdata;
  logic [3:0]  t_wstrb;
  int          t_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; plays the bus and the core side.
  task automatic run_txn(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int req_lo, input int resp_lo);
    int cyc = 0;
    int req_stall = 0;
    int resp_stall = 0;
    bit rsp_next = 0;
    bit done = 0;
    t_bus_seen = 0; t_wen = 0; t_req_stable = 1; t_resp_stable = 1;
    t_timeout = 0; t_err = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    t_wstrb = '0; t_lat = 0;
    i_req_valid = 1; i_req_wr = wr; i_req_memop = op; i_req_addr = addr; i_req_wdata = wdata;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      i_req_valid = 0;
      i_mem_rsp_valid = 0;
      if (rsp_next) begin
        i_mem_rsp_valid = 1;
        i_mem_rdata = rdata;
        rsp_next = 0;
      end
      if (o_mem_req_valid) begin
        if (!t_bus_seen) begin
          t_bus_seen = 1; t_addr = o_mem_addr; t_wstrb = o_mem_wstrb;
          t_wdata = o_mem_wdata; t_wen = o_mem_wen;
        end else if (o_mem_addr !== t_addr || o_mem_wstrb !== t_wstrb ||
                     o_mem_wdata !== t_wdata || o_mem_wen !== t_wen) begin
          t_req_stable = 0;
        end
        if (req_stall < req_lo) begin
          i_mem_req_ready = 0;
          req_stall++;
        end else begin
          i_mem_req_ready = 1;
          rsp_next = 1;
        end
      end else begin
        i_mem_req_ready = 0;
      end
      if (o_resp_valid) begin
        if (t_lat == 0) begin
          t_lat = cyc; t_rdata = o_resp_rdata; t_err = o_resp_err;
        end else if (o_resp_rdata !== t_rdata || o_resp_err !== t_err) begin
          t_resp_stable = 0;
        end
        if (o_req_ready) t_resp_stable = 0;
        if (resp_stall < resp_lo) begin
          i_resp_ready = 0;
          resp_stall++;
        end else begin
          i_resp_ready = 1;
        end
      end else if (t_lat != 0) begin
        done = 1;
        i_resp_ready = 0;
      end
    end
    if (!done) t_timeout = 1;
    i_resp_ready = 0;
    i_mem_req_ready = 0;
    i_mem_rsp_valid = 0;
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", {31'b0, o_resp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'b0, o_mem_req_valid}, 32'd0);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_resp_rdata", o_resp_rdata, 32'd0);
    rst_n = 1;
    @(negedge clk);
    check("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst_wstrb", {28'b0, o_mem_wstrb}, 32'd0);

    // LB at 0x1003
    run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0);
    check("lb_timeout", {31'b0, t_timeout}, 32'd0);
    check("lb_addr", t_addr, 32'h0000_1000);
    check("lb_wstrb", {28'b0, t_wstrb}, 32'd0);
    check("lb_wen", {31'b0, t_wen}, 32'd0);
    check("lb_rdata", t_rdata, 32'hFFFF_FF80);
    check("lb_err", {31'b0, t_err}, 32'd0);
    check("lb_latency", t_lat, 32'd3);

    // SH at 0x2002
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 0, 0);
    check("sh_timeout", {31'b0, t_timeout}, 32'd0);
    check("sh_wen", {31'b0, t_wen}, 32'd1);
    check("sh_wstrb", {28'b0, t_wstrb}, 32'hC);
    check("sh_wdata", t_wdata, 32'hABCD_ABCD);
    check("sh_addr", t_addr, 32'h0000_2000);
    check("sh_rdata", t_rdata, 32'd0);
    check("sh_err", {31'b0, t_err}, 32'd0);

    // LHU at 0x3002 with bus and core back-pressure
    run_txn(1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'h8001_FFFF, 5, 2);
    check("lhu_timeout", {31'b0, t_timeout}, 32'd0);
    check("lhu_req_stable", {31'b0, t_req_stable}, 32'd1);
    check("lhu_addr", t_addr, 32'h0000_3000);
    check("lhu_rdata", t_rdata, 32'h0000_8001);
    check("lhu_resp_stable", {31'b0, t_resp_stable}, 32'd1);
    check("lhu_latency", t_lat, 32'd8);

    // illegal store memop 100
    run_txn(1'b1, 3'b100, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0, 0, 0);
    check("ill_st_bus", {31'b0, t_bus_seen}, 32'd0);
    check("ill_st_err", {31'b0, t_err}, 32'd1);
    check("ill_st_rdata", t_rdata, 32'd0);
    check("ill_st_latency", t_lat, 32'd1);

    // illegal load memop 111
    run_txn(1'b0, 3'b111, 32'h0000_0044, 32'h0, 32'hFFFF_FFFF, 0, 0);
    check("ill_ld_bus", {31'b0, t_bus_seen}, 32'd0);
    check("ill_ld_err", {31'b0, t_err}, 32'd1);
    check("ill_ld_latency", t_lat, 32'd1);

    // LW at 0x4001 (misaligned)
    run_txn(1'b0, 3'b010, 32'h0000_4001, 32'h0, 32'hDEAD_BEEF, 0, 0);
    check("lw_mis_timeout", {31'b0, t_timeout}, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_bus", {31'b0, t_bus_seen}, 32'd0);
    check("lw_mis_err", {31'b0, t_err}, 32'd1);
    check("lw_mis_rdata", t_rdata, 32'd0);
`else
    check("lw_mis_addr", t_addr, 32'h0000_4000);
    check("lw_mis_rdata", t_rdata, 32'hDEAD_BEEF);
    check("lw_mis_err", {31'b0, t_err}, 32'd0);
`endif

    // SB at 0x0001
    run_txn(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0, 0, 0);
    check("sb_wstrb", {28'b0, t_wstrb}, 32'h2);
    check("sb_wdata", t_wdata, 32'hA5A5_A5A5);

    // LH at 0x0000 (negative lower half)
    run_txn(1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h1234_F00D, 0, 0);
    check("lh_rdata", t_rdata, 32'hFFFF_F00D);

    // LBU at 0x0102 (lane 2, zero-extended)
    run_txn(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h00C3_0000, 0, 0);
    check("lbu_rdata", t_rdata, 32'h0000_00C3);

    // SW at 0x0010
    run_txn(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 0, 0);
    check("sw_wstrb", {28'b0, t_wstrb}, 32'hF);
    check("sw_wdata", t_wdata, 32'hCAFE_F00D);

    // reset while the bus request is pending
    i_req_valid = 1; i_req_wr = 0; i_req_memop = 3'b010; i_req_addr = 32'h0000_5000;
    i_mem_req_ready = 0;
    @(negedge clk);
    i_req_valid = 0;
    check("rreq_pre_valid", {31'b0, o_mem_req_valid}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("rreq_async_drop", {31'b0, o_mem_req_valid}, 32'd0);
    check("rreq_req_ready", {31'b0, o_req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1;

    // reset while waiting for the bus response, then a late response
    @(negedge clk);
    i_req_valid = 1; i_req_wr = 0; i_req_memop = 3'b010; i_req_addr = 32'h0000_6000;
    @(negedge clk);
    i_req_valid = 0;
    i_mem_req_ready = 1;
    @(negedge clk);
    i_mem_req_ready = 0;
    check("rwait_in_wait", {30'b0, o_mem_req_valid, o_req_ready}, 32'd0);
    #2 rst_n = 0;
    #1;
    check("rwait_mem_addr", o_mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    i_mem_rsp_valid = 1; i_mem_rdata = 32'h1234_5678;
    @(negedge clk);
    i_mem_rsp_valid = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_resp_valid || o_mem_req_valid) seen = 1;
      @(negedge clk);
    end
    check("rwait_no_resp", {31'b0, seen}, 32'd0);
    check("rwait_req_ready", {31'b0, o_req_ready}, 32'd1);
    check("rwait_rdata", o_resp_rdata, 32'd0);
    check("rwait_err", {31'b0, o_resp_err}, 32'd0);

    // normal operation after reset
    run_txn(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'h0BAD_CAFE, 0, 0);
    check("post_rst_rdata", t_rdata, 32'h0BAD_CAFE);
    check("post_rst_latency", t_lat, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
